seq_mult_addshift: RTL and testbench

- Parametrised sequential add-shift multiplier; the next generation of the fixed 8-bit multiplier datapath.
- Holds an internal (WIDTH+1)-bit add/subtract unit, an accumulator A, a multiplier register B, a sign-extension bit X and a control FSM.
- Produces a 2*WIDTH-bit product in two's-complement (signed) or plain binary (unsigned) mode, selected per operation.
- Sits behind the board-level switch/button interface; result drives the hex display and LEDs.

---
 rtl/seq_mult_addshift.sv | 110 +++++++++++
 tb/tb_seq_mult_addshift.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_addshift.sv
// Sequential add-shift multiplier: one partial-product step per clock, signed or unsigned,
// producing {A,B} as a 2*WIDTH-bit product after WIDTH steps.
module seq_mult_addshift #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Run,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic [2*WIDTH-1:0] Product,
    output logic               X,
    output logic               Busy,
    output logic               Done
);

    // Run/Done handshake: a high Run sampled in IDLE starts an operation; Done stays
    // high until Run is sampled low, so every start needs Run to drop after completion.
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   s_reg;
    logic               x_reg;
    logic               mode;
    logic [CNT_W-1:0]   count;
    logic               busy_reg;
    logic               done_reg;

    logic [WIDTH:0]     ext_a;
    logic [WIDTH:0]     ext_s;
    logic [WIDTH:0]     sum;
    logic               last_step;

    assign last_step = (count == CNT_W'(WIDTH - 1));

    // The top multiplier bit carries negative weight in signed mode, hence the final subtract.
    always_comb begin
        ext_a = {mode & a_reg[WIDTH-1], a_reg};
        ext_s = {mode & s_reg[WIDTH-1], s_reg};
        sum   = ext_a;
        if (b_reg[0]) begin
            if (mode && last_step)
                sum = ext_a - ext_s;
            else
                sum = ext_a + ext_s;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            x_reg    <= 1'b0;
            mode     <= 1'b0;
            count    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        s_reg    <= Multiplicand;
                        b_reg    <= Multiplier;
                        a_reg    <= '0;
                        x_reg    <= 1'b0;
                        mode     <= Signed_Mode;
                        count    <= '0;
                        state    <= CALC;
                        busy_reg <= 1'b1;
                    end
                end
                CALC: begin
                    // sum[WIDTH] is the sign (signed) or the carry (unsigned); either way it becomes A's MSB.
                    a_reg <= sum[WIDTH:1];
                    b_reg <= {sum[0], b_reg[WIDTH-1:1]};
                    x_reg <= mode & sum[WIDTH];
                    count <= count + 1'b1;
                    if (last_step) begin
                        state    <= DONE;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (!Run) begin
                        state    <= IDLE;
                        done_reg <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign Product = {a_reg, b_reg};
    assign X       = x_reg;
    assign Busy    = busy_reg;
    assign Done    = done_reg;

endmodule

// File: tb/tb_seq_mult_addshift.sv
// Bench for seq_mult_addshift: WIDTH=8 and WIDTH=4 instances checked against an
// integer-arithmetic product model, plus Run/Done protocol and async reset scenarios.
module tb_seq_mult_addshift;

    logic        Clk;
    logic        Reset;
    logic        Run;
    logic        Signed_Mode;
    logic [7:0]  Multiplicand;
    logic [7:0]  Multiplier;
    logic [15:0] Product;
    logic        X;
    logic        Busy;
    logic        Done;

    logic        run4;
    logic        sgn4;
    logic [3:0]  mcand4;
    logic [3:0]  mplier4;
    logic [7:0]  product4;
    logic        x4;
    logic        busy4;
    logic        done4;

    int errors = 0;
    int checks = 0;

    seq_mult_addshift #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Signed_Mode(Signed_Mode),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .Product(Product), .X(X), .Busy(Busy), .Done(Done)
    );

    seq_mult_addshift #(.WIDTH(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Run(run4), .Signed_Mode(sgn4),
        .Multiplicand(mcand4), .Multiplier(mplier4),
        .Product(product4), .X(x4), .Busy(busy4), .Done(done4)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // reference model: exact integer product truncated to 2*w bits
    function automatic longint model_product(bit sgn, longint a, longint b, int w);
        longint p;
        longint mask;
        if (sgn && a[w-1]) a = a - (longint'(1) << w);
        if (sgn && b[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        mask = (longint'(1) << (2 * w)) - 1;
        return p & mask;
    endfunction

    function automatic bit model_x(bit sgn, longint p, int w);
        return sgn && p[2*w-1];
    endfunction

    // driver: start an 8-bit op; Run drops after drop_after edges (0 = hold high)
    task automatic run8(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                        input int drop_after, output int edges, output int busy_cycles);
        @(negedge Clk);
        Signed_Mode = sgn; Multiplicand = a; Multiplier = b; Run = 1'b1;
        edges = 0; busy_cycles = 0;
        while (edges < 40) begin
            @(posedge Clk); #1;
            edges++;
            if (Busy) busy_cycles++;
            if (drop_after != 0 && edges == drop_after) Run = 1'b0;
            if (Done) break;
        end
    endtask

    task automatic run4_op(input bit sgn, input logic [3:0] a, input logic [3:0] b,
                           output int edges);
        @(negedge Clk);
        sgn4 = sgn; mcand4 = a; mplier4 = b; run4 = 1'b1;
        edges = 0;
        while (edges < 40) begin
            @(posedge Clk); #1;
            edges++;
            if (edges == 1) run4 = 1'b0;
            if (done4) break;
        end
    endtask

    task automatic idle_edges(input int n);
        Run = 1'b0; run4 = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Run = 1'b0; run4 = 1'b0; Signed_Mode = 1'b0; sgn4 = 1'b0;
        Multiplicand = '0; Multiplier = '0; mcand4 = '0; mplier4 = '0;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if ({Product, X, Busy, Done} !== 19'd0) begin
            errors++; $display("FAIL reset_w8: got prod=%h x=%b busy=%b done=%b, need all 0", Product, X, Busy, Done);
        end
        checks++;
        if ({product4, x4, busy4, done4} !== 11'd0) begin
            errors++; $display("FAIL reset_w4: got prod=%h x=%b busy=%b done=%b, need all 0", product4, x4, busy4, done4);
        end
        @(negedge Clk); Reset = 1'b0;
        idle_edges(2);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got busy=%b done=%b, need 0 0", Busy, Done);
        end
    endtask

    task automatic test_signed_basic;
        int e, bc;
        run8(1'b1, 8'd7, 8'hFD, 1, e, bc);
        checks++;
        if (e !== 9) begin errors++; $display("FAIL latency_7x-3: got %0d edges, need 9", e); end
        checks++;
        if (Product !== 16'hFFEB || X !== 1'b1) begin
            errors++; $display("FAIL prod_7x-3: got %h x=%b, need ffeb x=1", Product, X);
        end
        checks++;
        if (bc !== 8) begin errors++; $display("FAIL busy_7x-3: got %0d busy cycles, need 8", bc); end
        @(posedge Clk); #1;
        checks++;
        if (Done !== 1'b0 || Product !== 16'hFFEB) begin
            errors++; $display("FAIL pulse_release: got done=%b prod=%h, need 0 ffeb", Done, Product);
        end
        idle_edges(1);
    endtask

    task automatic test_corners;
        int e, bc;
        logic [7:0] av [4] = '{8'h80, 8'hFF, 8'h5A, 8'h7F};
        logic [7:0] bv [4] = '{8'h80, 8'hFF, 8'h00, 8'h80};
        bit         sv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] exp_p;
        bit exp_x;
        for (int i = 0; i < 4; i++) begin
            run8(sv[i], av[i], bv[i], 1, e, bc);
            exp_p = 16'(model_product(sv[i], longint'(av[i]), longint'(bv[i]), 8));
            exp_x = model_x(sv[i], longint'(exp_p), 8);
            checks++;
            if (Product !== exp_p || X !== exp_x || e !== 9) begin
                errors++;
                $display("FAIL corner_%0d: got prod=%h x=%b edges=%0d, need prod=%h x=%b edges=9",
                         i, Product, X, e, exp_p, exp_x);
            end
            idle_edges(2);
        end
    endtask

    task automatic test_width4;
        int e;
        run4_op(1'b1, 4'h8, 4'h7, e);
        checks++;
        if (product4 !== 8'hC8 || x4 !== 1'b1 || e !== 5) begin
            errors++; $display("FAIL w4_-8x7: got prod=%h x=%b edges=%0d, need c8 x=1 edges=5", product4, x4, e);
        end
        idle_edges(2);
        run4_op(1'b0, 4'hF, 4'hF, e);
        checks++;
        if (product4 !== 8'hE1 || x4 !== 1'b0 || e !== 5) begin
            errors++; $display("FAIL w4_15x15: got prod=%h x=%b edges=%0d, need e1 x=0 edges=5", product4, x4, e);
        end
        idle_edges(2);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] a, b;
            bit s;
            logic [7:0] exp_p;
            a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); s = 1'($urandom_range(0, 1));
            run4_op(s, a, b, e);
            exp_p = 8'(model_product(s, longint'(a), longint'(b), 4));
            checks++;
            if (product4 !== exp_p || x4 !== model_x(s, longint'(exp_p), 4)) begin
                errors++; $display("FAIL w4_rand: s=%b %h*%h got %h x=%b, need %h", s, a, b, product4, x4, exp_p);
            end
            idle_edges(2);
        end
    endtask

    task automatic test_random;
        int e, bc;
        logic [7:0] a, b;
        bit s;
        logic [15:0] exp_p;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom_range(0, 1));
            run8(s, a, b, 1, e, bc);
            exp_p = 16'(model_product(s, longint'(a), longint'(b), 8));
            checks++;
            if (Product !== exp_p || X !== model_x(s, longint'(exp_p), 8) || e !== 9) begin
                errors++;
                $display("FAIL rand_%0d: s=%b %h*%h got prod=%h x=%b edges=%0d, need %h x=%b",
                         i, s, a, b, Product, X, e, exp_p, model_x(s, longint'(exp_p), 8));
            end
            idle_edges(1);
        end
    endtask

    task automatic test_hold_run;
        int e, bc, bad;
        logic [15:0] exp_p;
        exp_p = 16'(model_product(1'b1, 64'd100, 64'hC3, 8));
        run8(1'b1, 8'd100, 8'hC3, 0, e, bc);
        checks++;
        if (Product !== exp_p || e !== 9) begin
            errors++; $display("FAIL hold_prod: got %h edges=%0d, need %h edges=9", Product, e, exp_p);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            Multiplicand = 8'($urandom); Multiplier = 8'($urandom); Signed_Mode = ~Signed_Mode;
            @(posedge Clk); #1;
            if (Done !== 1'b1 || Busy !== 1'b0 || Product !== exp_p) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_done: %0d cycles left DONE or changed product, need 0 (prod=%h)", bad, Product);
        end
        Run = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || Product !== exp_p) begin
            errors++; $display("FAIL hold_release: got done=%b busy=%b prod=%h, need 0 0 %h", Done, Busy, Product, exp_p);
        end
        @(posedge Clk); #1;
        checks++;
        if (Busy !== 1'b0 || Product !== exp_p) begin
            errors++; $display("FAIL idle_hold: got busy=%b prod=%h, need 0 %h", Busy, Product, exp_p);
        end
    endtask

    task automatic test_drop_run;
        int e, bc;
        logic [15:0] exp_p;
        exp_p = 16'(model_product(1'b1, 64'hE9, 64'h35, 8));
        run8(1'b1, 8'hE9, 8'h35, 4, e, bc);
        checks++;
        if (Product !== exp_p || e !== 9 || bc !== 8) begin
            errors++; $display("FAIL drop_prod: got %h edges=%0d busy=%0d, need %h 9 8", Product, e, bc, exp_p);
        end
        @(posedge Clk); #1;
        checks++;
        if (Done !== 1'b0) begin errors++; $display("FAIL drop_done_len: got done=%b after one cycle, need 0", Done); end
        idle_edges(1);
    endtask

    task automatic test_reset_mid;
        int e, bc;
        @(negedge Clk);
        Signed_Mode = 1'b1; Multiplicand = 8'h9C; Multiplier = 8'h77; Run = 1'b1;
        @(posedge Clk); #1; Run = 1'b0;
        repeat (4) @(posedge Clk);
        #2; Reset = 1'b1;
        #1;
        checks++;
        if ({Product, X, Busy, Done} !== 19'd0) begin
            errors++; $display("FAIL reset_mid: got prod=%h x=%b busy=%b done=%b, need all 0", Product, X, Busy, Done);
        end
        @(negedge Clk); Reset = 1'b0;
        idle_edges(3);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 16'h0) begin
            errors++; $display("FAIL no_resume: got busy=%b done=%b prod=%h, need 0 0 0000", Busy, Done, Product);
        end
        run8(1'b1, 8'd5, 8'd6, 1, e, bc);
        checks++;
        if (Product !== 16'h001E || e !== 9) begin
            errors++; $display("FAIL after_reset: got %h edges=%0d, need 001e 9", Product, e);
        end
        idle_edges(1);
    endtask

    initial begin
        Reset = 1'b1;
        test_reset;
        test_signed_basic;
        test_corners;
        test_width4;
        test_random;
        test_hold_run;
        test_drop_run;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
